pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, width of all PC/address buses.
REQ-002 Parameter STALL_W, default 6, stall bus width; bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
REQ-003 Parameter EXC_VECTOR, default 32'h0000_0020, exception redirect target.
REQ-004 Parameter WDOG_MAX, default 255, consecutive-stall limit, 8-bit counter.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 stallreq_id  in  1  ID stage stall request.
REQ-008 stallreq_ex  in  1  EX stage stall request (multi-cycle op).
REQ-009 stallreq_mem  in  1  MEM stage stall request (data memory wait).
REQ-010 excp_i  in  1  exception raised by MEM stage.
REQ-011 branch_flag_i  in  1  branch taken, from ID.
REQ-012 branch_addr_i  in  ADDR_W  branch target, from ID.
REQ-013 stall  out  STALL_W  per-stage hold vector to pc/if/id/ex/mem/wb.
REQ-014 flush  out  1  clear all pipeline registers this cycle.
REQ-015 redirect  out  1  PC load strobe to PC generator.
REQ-016 new_pc  out  ADDR_W  PC load value, valid when redirect=1.
REQ-017 stall_timeout  out  1  sticky watchdog error flag.

Function
REQ-018 States: IDLE, FLUSH; state register, pending-branch valid/address, watchdog counter, timeout flag are the only storage.
REQ-019 stall, combinational, priority mem>ex>id: stallreq_mem -> 6'b011111; else stallreq_ex -> 6'b001111; else stallreq_id -> 6'b000111; else 6'b000000.
REQ-020 In FLUSH, stall forced to 6'b000000 regardless of requests.
REQ-021 IDLE -> FLUSH when excp_i=1 at posedge; FLUSH -> IDLE unconditionally after one cycle; excp_i ignored in FLUSH.
REQ-022 In FLUSH: flush=1, redirect=1, new_pc=EXC_VECTOR; branch inputs ignored.
REQ-023 flush=0 in IDLE.
REQ-024 IDLE, branch_flag_i=1 and stall[0]=0: redirect=1, new_pc=branch_addr_i same cycle.
REQ-025 IDLE, branch_flag_i=1 and stall[0]=1: branch latched as pending (valid=1, address=branch_addr_i) at posedge; redirect=0; newer branch while pending overwrites address.
REQ-026 IDLE, pending valid, stall[0]=0, branch_flag_i=0: redirect=1, new_pc=pending address; pending cleared at that posedge.
REQ-027 Live branch_flag_i with stall[0]=0 wins over pending; pending cleared same posedge.
REQ-028 Entering FLUSH (excp_i sampled) clears pending at that posedge.
REQ-029 redirect=0 and new_pc=0 when no redirect source active.
REQ-030 Watchdog counter increments each posedge with stall[0]=1, cleared on posedge with stall[0]=0, saturates at WDOG_MAX.
REQ-031 stall_timeout set at posedge where counter already equals WDOG_MAX and stall[0]=1; remains 1 until reset.
REQ-032 No output depends combinationally on stall_timeout; pipeline behaviour unchanged by timeout.

Reset
REQ-033 rst=1 asynchronously forces state=IDLE, pending valid=0, pending address=0, counter=0, stall_timeout=0.
REQ-034 During rst=1: stall follows REQ-019 from inputs, flush=0, redirect reflects only live branch per REQ-024; no state advances.
REQ-035 rst asserted while in FLUSH aborts flush immediately; first cycle after release is IDLE.

Verification
REQ-036 stallreq_id=1, stallreq_ex=1 same cycle -> stall=6'b001111; add stallreq_mem=1 -> 6'b011111; all drop -> 6'b000000.
REQ-037 stallreq_ex=1 three cycles, branch_flag_i=1 addr 32'h0000_0100 in first only -> redirect=0 while stalled, redirect=1 new_pc=32'h0000_0100 on first unstalled cycle, then 0.
REQ-038 excp_i=1 one cycle with stallreq_mem=1 and pending branch -> next cycle flush=1, redirect=1, new_pc=32'h0000_0020, stall=0; pending discarded; following cycle flush=0.
REQ-039 stallreq_id held 257 cycles (WDOG_MAX=255) -> stall_timeout=1 after 256th posedge, stays 1 after stall released; clears only on rst.
REQ-040 rst pulsed mid-FLUSH and mid-pending -> flush=0 immediately, no stale redirect after release.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard requests from the pipeline stages and the stall/flush/redirect controls back to them.
interface pipe_ctrl_if #(
   parameter int ADDR_W  = 32,
   parameter int STALL_W = 6
);
   logic               stallreq_id;
   logic               stallreq_ex;
   logic               stallreq_mem;
   logic               excp_i;
   logic               branch_flag_i;
   logic [ADDR_W-1:0]  branch_addr_i;
   logic [STALL_W-1:0] stall;
   logic               flush;
   logic               redirect;
   logic [ADDR_W-1:0]  new_pc;
   logic               stall_timeout;
   modport master (
      output stallreq_id, stallreq_ex, stallreq_mem, excp_i, branch_flag_i, branch_addr_i,
      input  stall, flush, redirect, new_pc, stall_timeout
   );
   modport slave (
      input  stallreq_id, stallreq_ex, stallreq_mem, excp_i, branch_flag_i, branch_addr_i,
      output stall, flush, redirect, new_pc, stall_timeout
   );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller -- stall priority, exception flush, branch redirect with
// deferral across stalls, and a sticky watchdog on runaway PC stalls.
module pipe_ctrl #(
   parameter int              ADDR_W     = 32,
   parameter int              STALL_W    = 6,
   parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_0020,
   parameter int              WDOG_MAX   = 255
) (
   input logic       clk,
   input logic       rst,
   pipe_ctrl_if.slave bus
);
   localparam logic [7:0] WMAX = 8'(WDOG_MAX);
   typedef enum logic {IDLE, FLUSH} state_t;
   state_t             state, state_n;
   logic               pend_v, pend_v_n;
   logic [ADDR_W-1:0]  pend_a, pend_a_n;
   logic [7:0]         cnt, cnt_n;
   logic               tmo, tmo_n;
   logic [STALL_W-1:0] stall_v;
   logic               in_flush, st0, live_br, pend_br, load;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         pend_v <= 1'b0;
         pend_a <= '0;
         cnt    <= '0;
         tmo    <= 1'b0;
      end else begin
         state  <= state_n;
         pend_v <= pend_v_n;
         pend_a <= pend_a_n;
         cnt    <= cnt_n;
         tmo    <= tmo_n;
      end
   end
   always_comb begin
      in_flush = state == FLUSH;
      stall_v  = in_flush          ? '0 :
                 bus.stallreq_mem ? STALL_W'(6'b011111) :
                 bus.stallreq_ex  ? STALL_W'(6'b001111) :
                 bus.stallreq_id  ? STALL_W'(6'b000111) : '0;
      st0      = stall_v[0];
      live_br  = !in_flush && bus.branch_flag_i && !st0;
      pend_br  = !in_flush && pend_v && !st0 && !bus.branch_flag_i;
      // a stalled PC cannot take the branch now, so park it until the stall lifts
      load     = !in_flush && !bus.excp_i && bus.branch_flag_i && st0;
      state_n  = (!in_flush && bus.excp_i) ? FLUSH : IDLE;
      pend_v_n = (in_flush || bus.excp_i) ? 1'b0 : st0 ? (bus.branch_flag_i || pend_v) : 1'b0;
      pend_a_n = load ? bus.branch_addr_i : pend_a;
      cnt_n    = st0 ? ((cnt == WMAX) ? cnt : cnt + 8'd1) : 8'd0;
      tmo_n    = tmo || (st0 && cnt == WMAX);
      bus.stall         = stall_v;
      bus.flush         = in_flush;
      bus.redirect      = in_flush || live_br || pend_br;
      bus.new_pc        = in_flush ? EXC_VECTOR : live_br ? bus.branch_addr_i : pend_br ? pend_a : '0;
      bus.stall_timeout = tmo;
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven scoreboard bench for pipe_ctrl plus hand sequences for async reset cases.
module tb_pipe_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   pipe_ctrl_if #(.ADDR_W(32), .STALL_W(6)) bus ();
   pipe_ctrl #(.ADDR_W(32), .STALL_W(6), .EXC_VECTOR(32'h0000_0020), .WDOG_MAX(255)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );
   typedef struct {
      logic        rst, id, ex, mem, xc, br;
      logic [31:0] addr;
      logic [5:0]  stall;
      logic        flush, redir;
      logic [31:0] pc;
      logic        tmo;
   } vec_t;
   int   passed = 0;
   int   total  = 0;
   int   row    = 0;
   vec_t exp_q[$];
   vec_t tbl[$];
   function automatic vec_t mk(input logic r, id, ex, mem, xc, br, input logic [31:0] a,
                               input logic [5:0] s, input logic f, rd, input logic [31:0] pc, input logic t);
      vec_t v;
      v.rst = r; v.id = id; v.ex = ex; v.mem = mem; v.xc = xc; v.br = br; v.addr = a;
      v.stall = s; v.flush = f; v.redir = rd; v.pc = pc; v.tmo = t;
      return v;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act === want) passed++;
      else $display("FAIL %s row %0d: got %0h want %0h", nm, row, act, want);
   endtask
   task automatic drive(input vec_t v);
      rst                = v.rst;
      bus.stallreq_id    = v.id;
      bus.stallreq_ex    = v.ex;
      bus.stallreq_mem   = v.mem;
      bus.excp_i         = v.xc;
      bus.branch_flag_i  = v.br;
      bus.branch_addr_i  = v.addr;
      exp_q.push_back(v);
   endtask
   task automatic compare();
      vec_t e;
      e = exp_q.pop_front();
      chk("stall", 32'(bus.stall), 32'(e.stall));
      chk("flush", 32'(bus.flush), 32'(e.flush));
      chk("redirect", 32'(bus.redirect), 32'(e.redir));
      chk("new_pc", bus.new_pc, e.pc);
      chk("stall_timeout", 32'(bus.stall_timeout), 32'(e.tmo));
      row++;
   endtask
   task automatic apply(input vec_t v);
      drive(v);
      @(negedge clk);
      compare();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_inputs();
      bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.stallreq_mem = 0;
      bus.excp_i = 0; bus.branch_flag_i = 0; bus.branch_addr_i = '0;
   endtask
   initial begin
      idle_inputs();
      #1;
      // held in reset: stall and live branch still combinational, nothing latches
      tbl.push_back(mk(1,0,0,0,0,0,32'h0,   6'h00,0,0,32'h0,0));
      tbl.push_back(mk(1,0,1,0,0,0,32'h0,   6'h0f,0,0,32'h0,0));
      tbl.push_back(mk(1,0,0,0,0,1,32'hA0,  6'h00,0,1,32'hA0,0));
      tbl.push_back(mk(1,1,0,0,0,1,32'hB0,  6'h07,0,0,32'h0,0));
      tbl.push_back(mk(1,0,0,0,1,0,32'h0,   6'h00,0,0,32'h0,0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h0,0));
      // stall priority
      tbl.push_back(mk(0,1,1,0,0,0,32'h0,   6'h0f,0,0,32'h0,0));
      tbl.push_back(mk(0,1,1,1,0,0,32'h0,   6'h1f,0,0,32'h0,0));
      tbl.push_back(mk(0,1,0,0,0,0,32'h0,   6'h07,0,0,32'h0,0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h0,0));
      // branch deferred across a three-cycle EX stall
      tbl.push_back(mk(0,0,1,0,0,1,32'h100, 6'h0f,0,0,32'h0,0));
      tbl.push_back(mk(0,0,1,0,0,0,32'h0,   6'h0f,0,0,32'h0,0));
      tbl.push_back(mk(0,0,1,0,0,0,32'h0,   6'h0f,0,0,32'h0,0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,1,32'h100,0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h0,0));
      // live branch, pending overwrite, live beats pending
      tbl.push_back(mk(0,0,0,0,0,1,32'h200, 6'h00,0,1,32'h200,0));
      tbl.push_back(mk(0,1,0,0,0,1,32'h300, 6'h07,0,0,32'h0,0));
      tbl.push_back(mk(0,1,0,0,0,1,32'h400, 6'h07,0,0,32'h0,0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,1,32'h400,0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h0,0));
      tbl.push_back(mk(0,0,0,1,0,1,32'h500, 6'h1f,0,0,32'h0,0));
      tbl.push_back(mk(0,0,0,0,0,1,32'h600, 6'h00,0,1,32'h600,0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h0,0));
      // exception with pending branch under MEM stall
      tbl.push_back(mk(0,1,0,0,0,1,32'h700, 6'h07,0,0,32'h0,0));
      tbl.push_back(mk(0,0,0,1,1,0,32'h0,   6'h1f,0,0,32'h0,0));
      tbl.push_back(mk(0,0,0,1,0,1,32'h800, 6'h00,1,1,32'h20,0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h0,0));
      // exception held two cycles: second one lands in FLUSH and is ignored
      tbl.push_back(mk(0,0,0,0,1,0,32'h0,   6'h00,0,0,32'h0,0));
      tbl.push_back(mk(0,0,0,0,1,0,32'h0,   6'h00,1,1,32'h20,0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h0,0));
      foreach (tbl[i]) apply(tbl[i]);
      // watchdog: flag rises after the 256th consecutive stalled posedge
      for (int i = 0; i <= 256; i++) apply(mk(0,1,0,0,0,0,32'h0, 6'h07,0,0,32'h0, i >= 256));
      for (int i = 0; i < 3; i++) apply(mk(0,0,0,0,0,0,32'h0, 6'h00,0,0,32'h0,1));
      apply(mk(1,0,0,0,0,0,32'h0, 6'h00,0,0,32'h0,0));
      apply(mk(0,0,0,0,0,0,32'h0, 6'h00,0,0,32'h0,0));
      // async reset mid-FLUSH
      apply(mk(0,0,0,0,1,0,32'h0, 6'h00,0,0,32'h0,0));
      idle_inputs();
      #1 chk("flush_before_rst", 32'(bus.flush), 32'd1);
      #1 rst = 1;
      #1 chk("flush_in_rst", 32'(bus.flush), 32'd0);
      chk("redirect_in_rst", 32'(bus.redirect), 32'd0);
      chk("new_pc_in_rst", bus.new_pc, 32'h0);
      @(negedge clk) rst = 0;
      @(posedge clk) #1;
      apply(mk(0,0,0,0,0,0,32'h0, 6'h00,0,0,32'h0,0));
      // async reset while a branch is pending
      apply(mk(0,1,0,0,0,1,32'hC0, 6'h07,0,0,32'h0,0));
      bus.branch_flag_i = 0;
      #1 rst = 1;
      #1 bus.stallreq_id = 0;
      #1 chk("redirect_pend_rst", 32'(bus.redirect), 32'd0);
      chk("new_pc_pend_rst", bus.new_pc, 32'h0);
      @(negedge clk) rst = 0;
      @(posedge clk) #1;
      apply(mk(0,0,0,0,0,0,32'h0, 6'h00,0,0,32'h0,0));
      apply(mk(0,0,0,0,0,0,32'h0, 6'h00,0,0,32'h0,0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
